vend_dispenser: RTL

- Physical-output end of the vending controller interface.
- Consumes the controller's single-cycle `choco` and `change` pulses and queues them in pending counters.
- Drives the product motor and the change-coin ejector, closing the loop with drop sensors and a vend timeout.
- Sits between the vending FSM and the mechanism drivers; reports busy, fault and overflow status.

---
 rtl/vend_dispenser_if.sv | 24 ++
 rtl/vend_dispenser.sv | 103 ++++++++++
 2 files changed

// File: rtl/vend_dispenser_if.sv
// Request/status bundle between the vending controller and the dispenser mechanism driver.
// The controller side is the master; the dispenser is the slave.
interface vend_dispenser_if;
  logic choco;
  logic change;
  logic item_sensed;
  logic clr_fault;
  logic motor_on;
  logic eject_on;
  logic vend_done;
  logic busy;
  logic fault;
  logic overflow;

  modport master (
    output choco, change, item_sensed, clr_fault,
    input  motor_on, eject_on, vend_done, busy, fault, overflow
  );

  modport slave (
    input  choco, change, item_sensed, clr_fault,
    output motor_on, eject_on, vend_done, busy, fault, overflow
  );
endinterface

// File: rtl/vend_dispenser.sv
// Dispenser back end: queues product/change pulses, runs the motor with a drop-sensor
// timeout, fires the coin ejector for a fixed pulse, and reports busy/fault/overflow.
module vend_dispenser #(
  parameter int QDEPTH       = 4,
  parameter int TIMEOUT      = 64,
  parameter int EJECT_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  vend_dispenser_if.slave bus
);
  localparam int            CW         = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL      = CW'(QDEPTH);
  localparam logic [7:0]    VEND_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0]    EJECT_LAST = 8'(EJECT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VEND, EJECT, FAULT} state_t;

  state_t        state, next_state;
  logic [CW-1:0] pend_choco, pend_change;
  logic [CW-1:0] pend_choco_nxt, pend_change_nxt;
  logic          drop_choco, drop_change;
  logic [7:0]    timer;
  logic          overflow_q;
  logic          done_q;
  logic          start_vend, start_eject;

  // Returns {dropped, next_count}; a same-cycle request and service cancel out.
  function automatic logic [CW:0] bump(input logic [CW-1:0] cnt, input logic inc,
                                       input logic dec);
    logic [CW:0] res;
    res = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == QFULL) res[CW] = 1'b1;
      else              res[CW-1:0] = cnt + CW'(1);
    end else if (dec && !inc) begin
      res[CW-1:0] = cnt - CW'(1);
    end
    return res;
  endfunction

  // Product wins over change, so a sale always ejects its change after the item.
  assign start_vend  = (state == IDLE) && (pend_choco != '0);
  assign start_eject = (state == IDLE) && (pend_choco == '0) && (pend_change != '0);

  always_comb begin
    {drop_choco, pend_choco_nxt}   = bump(pend_choco, bus.choco, start_vend);
    {drop_change, pend_change_nxt} = bump(pend_change, bus.change, start_eject);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (which would infer a latch).
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start_vend)       next_state = VEND;
        else if (start_eject) next_state = EJECT;
      end
      VEND: begin
        if (bus.item_sensed)         next_state = IDLE;
        else if (timer == VEND_LAST) next_state = FAULT;
      end
      EJECT: if (timer == EJECT_LAST) next_state = IDLE;
      FAULT: if (bus.clr_fault)       next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
  end

  // Queues, service timer and sticky/pulse status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_choco  <= '0;
      pend_change <= '0;
      timer       <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pend_choco  <= pend_choco_nxt;
      pend_change <= pend_change_nxt;
      overflow_q  <= overflow_q | drop_choco | drop_change;
      done_q      <= (state == VEND) && bus.item_sensed;
      timer       <= (state == VEND || state == EJECT) ? timer + 8'd1 : 8'd0;
    end
  end

  // Moore outputs
  always_comb begin
    bus.motor_on  = (state == VEND);
    bus.eject_on  = (state == EJECT);
    bus.fault     = (state == FAULT);
    bus.vend_done = done_q;
    bus.overflow  = overflow_q;
    bus.busy      = (state != IDLE) || (pend_choco != '0) || (pend_change != '0);
  end
endmodule
